contador_ctrl: RTL and testbench

- Sequencer for the 8-bit loadable up/down counter (load, key, entrada in; counter_out out).
- Accepts a command (start value, end value) and preloads the counter. It then steps the counter toward the end value one count per clock and holds it there. It reports completion.
- The counter has no enable. The controller freezes it by asserting load with the current value.
- Sits between a command source (bench or upstream FSM) and one counter instance.

---
 rtl/contador_ctrl_if.sv | 17 +
 rtl/contador_ctrl.sv | 117 +++++++++++
 tb/tb_contador_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/contador_ctrl_if.sv
// Command channel between a command source and contador_ctrl.
//   cmd_valid : source has a command on cmd_start/cmd_end
//   cmd_ready : controller can take a command this cycle
//   cmd_start : counter preload value
//   cmd_end   : terminal counter value
// master = command source, slave = controller.
interface contador_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;

  modport master (output cmd_valid, output cmd_start, output cmd_end, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_start, input cmd_end, output cmd_ready);
endinterface

// File: rtl/contador_ctrl.sv
// Sequencer for an 8-bit loadable up/down counter (load, key, entrada in;
// counter_out out). Accepts a (start, end) command, preloads the counter,
// steps it one count per clock toward end and freezes it there, then pulses
// done. The counter has no enable, so it is frozen by loading its own value.
// Ports:
//   clock, reset        : posedge clock, synchronous active-high reset
//   cmd (slave)         : command channel (valid/ready, start, end)
//   pause, abort        : freeze counting (RUN) / end the current command
//   cnt_value           : counter_out of the controlled counter
//   cnt_load/key/entrada: counter controls (key 1 = up), all registered
//   busy, done, aborted : status; done/aborted are one-cycle pulses
// The counter samples its controls on negedge, so a value driven here at a
// posedge is visible on cnt_value by the next posedge.
module contador_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  contador_ctrl_if.slave   cmd,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic             cnt_key,
  output logic [WIDTH-1:0] cnt_entrada,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic             dir_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      start_q       <= '0;
      end_q         <= '0;
      dir_q         <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      cnt_load      <= 1'b1;
      cnt_key       <= 1'b0;
      cnt_entrada   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      // Default: freeze the counter at its present value.
      done        <= 1'b0;
      aborted     <= 1'b0;
      cnt_load    <= 1'b1;
      cnt_entrada <= cnt_value;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            start_q       <= cmd.cmd_start;
            end_q         <= cmd.cmd_end;
            dir_q         <= (cmd.cmd_end >= cmd.cmd_start);
            cnt_key       <= (cmd.cmd_end >= cmd.cmd_start);
            // Preload is issued with the accept so the counter holds start
            // by the first LOAD posedge.
            cnt_entrada   <= cmd.cmd_start;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= LOAD;
          end else begin
            cmd.cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= DONE;
          end else if (start_q == end_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt_load <= 1'b0;
            cnt_key  <= dir_q;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= DONE;
          end else if (cnt_value == end_q) begin
            // Load end_q before the next negedge so the counter never steps
            // past the terminal value.
            cnt_entrada <= end_q;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else if (!pause) begin
            cnt_load <= 1'b0;
            cnt_key  <= dir_q;
          end
        end
        DONE: begin
          cmd.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl with a behavioural negedge counter attached.
// Outputs are observed 1 ns after each posedge; at that point cnt_value is
// still the value the controller sampled at that posedge.
module tb_contador_ctrl;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cnt_value;
  logic         cnt_load, cnt_key, busy, done, aborted;
  logic [W-1:0] cnt_entrada;

  contador_ctrl_if #(.WIDTH(W)) cif ();

  contador_ctrl #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd         (cif.slave),
    .pause       (pause),
    .abort       (abort),
    .cnt_value   (cnt_value),
    .cnt_load    (cnt_load),
    .cnt_key     (cnt_key),
    .cnt_entrada (cnt_entrada),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  always #5 clock = ~clock;

  // Loadable up/down counter, acting on negedge.
  always @(negedge clock) begin
    if (cnt_load)     cnt_value <= cnt_entrada;
    else if (cnt_key) cnt_value <= cnt_value + 8'd1;
    else              cnt_value <= cnt_value - 8'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // lat: posedges from accept until done is seen by an edge-sampling
  // consumer (done registered at posedge n is sampled at posedge n+1).
  typedef struct {
    logic [7:0] s, e;
    int         pause_at, abort_at, lat, hold_n;
    logic [7:0] fin, lo, hi;
    logic       key, ab;
  } vec_t;

  function automatic vec_t mk(input int s, e, pause_at, abort_at, lat, hold_n,
                              fin, lo, hi, key, ab);
    vec_t v;
    v.s = 8'(s); v.e = 8'(e); v.pause_at = pause_at; v.abort_at = abort_at;
    v.lat = lat; v.hold_n = hold_n; v.fin = 8'(fin); v.lo = 8'(lo);
    v.hi = 8'(hi); v.key = 1'(key); v.ab = 1'(ab);
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int w = 0;
    while (cif.cmd_ready !== 1'b1 && w < 20) begin tick(); w++; end
    check({tag, " ready"}, int'(cif.cmd_ready), 1);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int lat = 0, holdn = 0, pleft = 0;
    bit pused = 0, aused = 0, stays = 1;
    logic [7:0] lo = 8'hff, hi = 8'h00;
    logic key_seen = 1'b0, ab_seen = 1'b0;
    wait_ready(tag);
    cif.cmd_valid = 1'b1; cif.cmd_start = v.s; cif.cmd_end = v.e;
    tick();
    check({tag, " busy@accept"}, int'(busy), 1);
    check({tag, " ready@accept"}, int'(cif.cmd_ready), 0);
    // Later changes on the command bus must not matter.
    cif.cmd_valid = 1'b0; cif.cmd_start = ~v.s; cif.cmd_end = ~v.e;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (pleft > 0) begin pleft--; if (pleft == 0) pause = 1'b0; end
      if (abort) abort = 1'b0;
      if (n == 1) key_seen = cnt_key;
      if (cnt_value < lo) lo = cnt_value;
      if (cnt_value > hi) hi = cnt_value;
      if (v.pause_at >= 0 && int'(cnt_value) == v.pause_at) holdn++;
      if (done) begin lat = n + 1; ab_seen = aborted; break; end
      // Seeing at-1 now means the controller sees at on the next posedge.
      if (v.pause_at > 0 && !pused && int'(cnt_value) == v.pause_at - 1) begin
        pause = 1'b1; pleft = 3; pused = 1;
      end
      if (v.abort_at > 0 && !aused && int'(cnt_value) == v.abort_at - 1) begin
        abort = 1'b1; aused = 1;
      end
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " aborted"}, int'(ab_seen), int'(v.ab));
    check({tag, " key"}, int'(key_seen), int'(v.key));
    check({tag, " min value"}, int'(lo), int'(v.lo));
    check({tag, " max value"}, int'(hi), int'(v.hi));
    if (v.pause_at >= 0) check({tag, " pause hold"}, holdn, v.hold_n);
    tick();
    check({tag, " done width"}, int'(done), 0);
    check({tag, " ready after done"}, int'(cif.cmd_ready), 1);
    for (int i = 0; i < 5; i++) begin
      if (cnt_value !== v.fin) stays = 0;
      tick();
    end
    check({tag, " final held"}, int'(stays), 1);
    check({tag, " final value"}, int'(cnt_value), int'(v.fin));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  vec_t vecs[7];

  initial begin
    int n;
    bit seen_done;
    vecs[0] = mk( 10,  15,  -1, -1,   7, 0,  15,  10,  15, 1, 0);
    vecs[1] = mk(200, 195,  -1, -1,   7, 0, 195, 195, 200, 0, 0);
    vecs[2] = mk( 42,  42,  -1, -1,   2, 0,  42,  42,  42, 1, 0);
    // 255 steps plus 3 paused cycles; 100 observed on 4 posedges.
    vecs[3] = mk(  0, 255, 100, -1, 260, 4, 255,   0, 255, 1, 0);
    // abort while the controller sees 7: frozen at 7.
    vecs[4] = mk(  3,  20,  -1,  7,   6, 0,   7,   3,   7, 1, 1);
    vecs[5] = mk(255,   0,  -1, -1, 257, 0,   0,   0, 255, 0, 0);
    vecs[6] = mk(  5,   4,  -1, -1,   3, 0,   4,   4,   5, 0, 0);

    cif.cmd_valid = 1'b0; cif.cmd_start = '0; cif.cmd_end = '0;
    reset = 1'b1;
    tick(); tick();
    check("reset ready", int'(cif.cmd_ready), 0);
    check("reset load", int'(cnt_load), 1);
    check("reset entrada", int'(cnt_entrada), 0);
    check("reset key", int'(cnt_key), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset aborted", int'(aborted), 0);
    reset = 1'b0;
    tick();
    check("ready after reset", int'(cif.cmd_ready), 1);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Reset while running 0 -> 100, controller sees 50 on the reset edge.
    wait_ready("rst");
    cif.cmd_valid = 1'b1; cif.cmd_start = 8'd0; cif.cmd_end = 8'd100;
    tick();
    cif.cmd_valid = 1'b0;
    n = 0;
    while (cnt_value != 8'd49 && n < 100) begin tick(); n++; end
    check("rst reached 49", int'(cnt_value), 49);
    reset = 1'b1;
    tick();
    check("rst load", int'(cnt_load), 1);
    check("rst entrada", int'(cnt_entrada), 0);
    check("rst ready", int'(cif.cmd_ready), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    reset = 1'b0;
    seen_done = 0;
    tick();
    check("rst ready after", int'(cif.cmd_ready), 1);
    check("rst counter cleared", int'(cnt_value), 0);
    for (int i = 0; i < 5; i++) begin
      if (done) seen_done = 1;
      tick();
    end
    check("rst no done", int'(seen_done), 0);

    // Back-to-back: valid held through DONE, second command 8 -> 6 queued.
    wait_ready("b2b");
    cif.cmd_valid = 1'b1; cif.cmd_start = 8'd1; cif.cmd_end = 8'd3;
    tick();
    cif.cmd_start = 8'd8; cif.cmd_end = 8'd6;
    n = 0;
    do begin tick(); n++; end while (!done && n < 20);
    check("b2b first latency", n + 1, 4);
    check("b2b first value", int'(cnt_value), 3);
    check("b2b ready in done", int'(cif.cmd_ready), 0);
    tick();
    check("b2b ready after done", int'(cif.cmd_ready), 1);
    check("b2b not yet accepted", int'(busy), 0);
    tick();
    check("b2b accepted", int'(busy), 1);
    check("b2b ready low", int'(cif.cmd_ready), 0);
    cif.cmd_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!done && n < 20);
    check("b2b second latency", n + 1, 4);
    check("b2b second value", int'(cnt_value), 6);
    check("b2b second aborted", int'(aborted), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
